// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default frame geometry and parity mode selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int DEFAULT_DATA_BITS     = 8;
  localparam int DEFAULT_TICKS_PER_BIT = 2;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, framed as start,
// LSB-first data, optional parity and 1-2 stop bits, paced by baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = PAR_MODE_EVEN,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int              TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            state, state_d;
  logic [TW-1:0]        tcnt, tcnt_d;
  logic [3:0]           bitcnt, bitcnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par, par_d;
  logic                 tx_d, tx_ready_d, tx_busy_d;
  logic                 bit_end;

  assign bit_end = baud_tick && (tcnt == TCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      tcnt     <= tcnt_d;
      bitcnt   <= bitcnt_d;
      shreg    <= shreg_d;
      par      <= par_d;
      tx       <= tx_d;
      tx_ready <= tx_ready_d;
      tx_busy  <= tx_busy_d;
    end
  end

  // Outputs are computed one cycle ahead so tx/tx_ready/tx_busy leave flops.
  always_comb begin
    state_d    = state;
    tcnt_d     = tcnt;
    bitcnt_d   = bitcnt;
    shreg_d    = shreg;
    par_d      = par;
    tx_d       = tx;
    tx_ready_d = tx_ready;
    tx_busy_d  = tx_busy;

    if (state != IDLE && state != SYNC && baud_tick)
      tcnt_d = bit_end ? '0 : tcnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d    = tx_data;
          par_d      = (^tx_data) ^ (PARITY_ODD != 0);
          state_d    = SYNC;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
          tx_d       = 1'b1;
        end
      end
      // The tick that ends SYNC marks the start-bit boundary, so it is not counted in tcnt.
      SYNC: begin
        if (baud_tick) begin
          state_d = START;
          tcnt_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bitcnt_d = '0;
          tx_d     = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (bitcnt == DATA_LAST) begin
            bitcnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt + 1'b1;
            tx_d     = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          bitcnt_d = '0;
          tx_d     = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bitcnt == STOP_LAST) begin
            state_d    = IDLE;
            bitcnt_d   = '0;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
            tx_d       = 1'b1;
          end else begin
            bitcnt_d = bitcnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
